// File: rtl/systolic_ctrl.sv
// Systolic array job controller: sequences the weight load, streams input
// vectors through the array, drains the pipeline and signals completion.
// Results appear PIPE_LAT cycles after the data read that produced them.
module systolic_ctrl #(
    parameter int ARRAY_SIZE = 8,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_WIDTH-1:0] num_vec,
    output logic                  w_rd_en,
    output logic [ADDR_WIDTH-1:0] w_addr,
    output logic                  weight_load,
    output logic                  d_rd_en,
    output logic [ADDR_WIDTH-1:0] d_addr,
    output logic                  systolic_en,
    output logic                  out_valid,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic                  busy,
    output logic                  done
);

    localparam int PIPE_LAT = 2 * ARRAY_SIZE;
    // One counter serves all three phases, so it must hold both the largest
    // address and the drain length.
    localparam int CNT_W = (ADDR_WIDTH > $clog2(PIPE_LAT)) ? ADDR_WIDTH : $clog2(PIPE_LAT);
    localparam logic [CNT_W-1:0] W_LAST = CNT_W'(ARRAY_SIZE - 1);
    localparam logic [CNT_W-1:0] D_LAST = CNT_W'(PIPE_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_W,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   num_vec_q, num_vec_d;
    logic [PIPE_LAT-1:0]     pipe_q;
    logic [ADDR_WIDTH-1:0]   out_addr_q;
    logic                    weight_load_q;
    logic                    kill;
    logic                    accept;
    logic [CNT_W-1:0]        v_last;

    assign v_last = CNT_W'(num_vec_q) - CNT_W'(1);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and counter logic; abort overrides every other transition
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        num_vec_d = num_vec_q;
        kill      = 1'b0;
        accept    = 1'b0;
        if (state_q != S_IDLE && abort) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            kill    = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        accept    = 1'b1;
                        num_vec_d = num_vec;
                        cnt_d     = '0;
                        state_d   = (num_vec == '0) ? S_DONE : S_LOAD_W;
                    end
                end
                S_LOAD_W: begin
                    if (cnt_q == W_LAST) begin
                        cnt_d   = '0;
                        state_d = S_STREAM;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_STREAM: begin
                    if (cnt_q == v_last) begin
                        cnt_d   = '0;
                        state_d = S_DRAIN;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_DRAIN: begin
                    if (cnt_q == D_LAST) begin
                        cnt_d   = '0;
                        state_d = S_DONE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Counters, latched job length, result pipe and weight-load delay
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q         <= '0;
            num_vec_q     <= '0;
            pipe_q        <= '0;
            out_addr_q    <= '0;
            weight_load_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            num_vec_q <= num_vec_d;
            if (kill) begin
                pipe_q        <= '0;
                out_addr_q    <= '0;
                weight_load_q <= 1'b0;
            end else begin
                pipe_q        <= {pipe_q[PIPE_LAT-2:0], d_rd_en};
                weight_load_q <= w_rd_en;
                if (accept) begin
                    out_addr_q <= '0;
                end else if (out_valid) begin
                    out_addr_q <= out_addr_q + ADDR_WIDTH'(1);
                end
            end
        end
    end

    // Outputs decoded from state; addresses read as zero when not strobed
    always_comb begin
        w_rd_en     = (state_q == S_LOAD_W);
        d_rd_en     = (state_q == S_STREAM);
        systolic_en = (state_q == S_STREAM) || (state_q == S_DRAIN);
        busy        = (state_q != S_IDLE);
        done        = (state_q == S_DONE);
        out_valid   = pipe_q[PIPE_LAT-1];
        weight_load = weight_load_q;
        w_addr      = w_rd_en ? cnt_q[ADDR_WIDTH-1:0] : '0;
        d_addr      = d_rd_en ? cnt_q[ADDR_WIDTH-1:0] : '0;
        out_addr    = out_valid ? out_addr_q : '0;
    end

endmodule

// File: tb/tb_systolic_ctrl.sv
// Scoreboard bench for systolic_ctrl: the driver computes, for every accepted
// job, the cycle and address of every strobe and pushes them into per-signal
// queues; a negedge monitor pops and compares against what the DUT shows.
module tb_systolic_ctrl;

    localparam int AS = 8;
    localparam int AW = 10;
    localparam int PL = 2 * AS;

    logic          clk;
    logic          rst;
    logic          start;
    logic          abort;
    logic [AW-1:0] num_vec;
    logic          w_rd_en;
    logic [AW-1:0] w_addr;
    logic          weight_load;
    logic          d_rd_en;
    logic [AW-1:0] d_addr;
    logic          systolic_en;
    logic          out_valid;
    logic [AW-1:0] out_addr;
    logic          busy;
    logic          done;

    systolic_ctrl #(.ARRAY_SIZE(AS), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .num_vec(num_vec),
        .w_rd_en(w_rd_en), .w_addr(w_addr), .weight_load(weight_load),
        .d_rd_en(d_rd_en), .d_addr(d_addr), .systolic_en(systolic_en),
        .out_valid(out_valid), .out_addr(out_addr), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int val;
    } ev_t;

    // 0 w_rd_en, 1 weight_load, 2 d_rd_en, 3 out_valid, 4 done
    ev_t   q [5][$];
    string names [5] = '{"w_rd_en", "weight_load", "d_rd_en", "out_valid", "done"};
    int    busy_from = 0, busy_to = -1, sys_from = 0, sys_to = -1;
    int    checks = 0, errors = 0;
    logic  stb [5];
    int    val [5];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
        end
    endtask

    function automatic void model_reset();
        for (int k = 0; k < 5; k++) q[k] = {};
        busy_from = 0; busy_to = -1; sys_from = 0; sys_to = -1;
    endfunction

    // Input seen by the DUT during cycle c; takes effect at the next edge.
    function automatic void model(input int c, input logic s, input logic a, input int n);
        bit   in_job;
        int   dn;
        ev_t  tmp [$];
        in_job = (c >= busy_from) && (c <= busy_to);
        if (a && in_job) begin
            for (int k = 0; k < 5; k++) begin
                tmp = {};
                for (int i = 0; i < q[k].size(); i++)
                    if (q[k][i].cyc <= c) tmp.push_back(q[k][i]);
                q[k] = tmp;
            end
            busy_to = c;
            if (sys_to > c) sys_to = c;
        end else if (s && !in_job) begin
            if (n == 0) begin
                dn = c + 1;
                sys_from = 0; sys_to = -1;
            end else begin
                for (int i = 0; i < AS; i++) begin
                    q[0].push_back('{c + 1 + i, i});
                    q[1].push_back('{c + 2 + i, -1});
                end
                for (int j = 0; j < n; j++) begin
                    q[2].push_back('{c + 1 + AS + j, j});
                    q[3].push_back('{c + 1 + AS + PL + j, j});
                end
                dn = c + 1 + AS + n + PL;
                sys_from = c + 1 + AS; sys_to = dn - 1;
            end
            q[4].push_back('{dn, -1});
            busy_from = c + 1; busy_to = dn;
        end
    endfunction

    // Monitor: sample mid-cycle and pop whatever the model expects now
    always @(negedge clk) begin
        if (!rst) begin
            stb = '{w_rd_en, weight_load, d_rd_en, out_valid, done};
            val = '{int'(w_addr), 0, int'(d_addr), int'(out_addr), 0};
            for (int k = 0; k < 5; k++) begin
                bit  hit;
                ev_t e;
                hit = (q[k].size() > 0) && (q[k][0].cyc == cyc);
                chk(names[k], int'(stb[k]), int'(hit));
                if (hit) begin
                    e = q[k].pop_front();
                    if (e.val >= 0 && stb[k]) chk({names[k], "_addr"}, val[k], e.val);
                end
            end
            chk("busy", int'(busy), int'(cyc >= busy_from && cyc <= busy_to));
            chk("systolic_en", int'(systolic_en), int'(cyc >= sys_from && cyc <= sys_to));
        end
    end

    task automatic step(input logic s, input logic a, input int n);
        start   = s;
        abort   = a;
        num_vec = AW'(n);
        model(cyc, s, a, n);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_w_rd_en"}, int'(w_rd_en), 0);
        chk({tag, "_w_addr"}, int'(w_addr), 0);
        chk({tag, "_weight_load"}, int'(weight_load), 0);
        chk({tag, "_d_rd_en"}, int'(d_rd_en), 0);
        chk({tag, "_d_addr"}, int'(d_addr), 0);
        chk({tag, "_systolic_en"}, int'(systolic_en), 0);
        chk({tag, "_out_valid"}, int'(out_valid), 0);
        chk({tag, "_out_addr"}, int'(out_addr), 0);
    endtask

    // Asynchronous reset raised between edges; outputs must clear at once
    task automatic rst_pulse();
        start = 1'b0;
        abort = 1'b0;
        #1 rst = 1'b1;
        model_reset();
        #1 chk_zero("async_rst");
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; num_vec = '0;
        repeat (3) @(posedge clk);
        #1 chk_zero("reset");
        rst = 1'b0;

        // Reference job: four vectors
        step(1, 0, 4);
        repeat (34) step(0, 0, 4);

        // Empty job: immediate done, no strobes
        step(1, 0, 0);
        repeat (4) step(0, 0, 0);

        // Abort in the eleventh cycle of a job; num_vec wiggles mid-job
        step(1, 0, 4);
        repeat (10) step(0, 0, 9);
        step(0, 1, 9);
        repeat (25) step(0, 0, 0);

        // Start held high: second job starts the cycle after DONE
        repeat (60) step(1, 0, 4);
        repeat (4) step(0, 0, 0);

        // Reset in cycle 20 of a job, then a full job afterwards
        step(1, 0, 4);
        repeat (19) step(0, 0, 4);
        rst_pulse();
        step(1, 0, 4);
        repeat (34) step(0, 0, 4);

        // Abort while idle has no effect on a start in the same cycle
        step(1, 1, 3);
        repeat (33) step(0, 0, 3);

        // Randomized traffic
        repeat (1500) begin
            if ($urandom_range(0, 399) == 0) begin
                rst_pulse();
            end else begin
                step(($urandom_range(0, 7) == 0),
                     ($urandom_range(0, 99) == 0),
                     ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 30)));
            end
        end
        repeat (80) step(0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/systolic_ctrl.md
SYSTOLIC_CTRL -- requirements
Module: systolic_ctrl

Interface
REQ-001 SHALL have parameter ARRAY_SIZE, default 8, systolic array dimension (PE rows = PE columns).
REQ-002 SHALL have parameter ADDR_WIDTH, default 10, width of every address and of num_vec.
REQ-003 SHALL have localparam PIPE_LAT = 2*ARRAY_SIZE, cycles from a data read to its result.
REQ-004 SHALL have port clk, input, 1, single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port start, input, 1, one-cycle job request; sampled only in IDLE.
REQ-007 SHALL have port abort, input, 1, cancel the running job.
REQ-008 SHALL have port num_vec, input, ADDR_WIDTH, number of input vectors; latched when start is accepted.
REQ-009 SHALL have port w_rd_en, output, 1, weight SRAM read strobe.
REQ-010 SHALL have port w_addr, output, ADDR_WIDTH, weight SRAM row address.
REQ-011 SHALL have port weight_load, output, 1, array latches weight row; w_rd_en delayed 1 cycle (SRAM latency 1).
REQ-012 SHALL have port d_rd_en, output, 1, data SRAM read strobe.
REQ-013 SHALL have port d_addr, output, ADDR_WIDTH, data SRAM address.
REQ-014 SHALL have port systolic_en, output, 1, array advance enable.
REQ-015 SHALL have port out_valid, output, 1, array data_out is valid this cycle.
REQ-016 SHALL have port out_addr, output, ADDR_WIDTH, result write address.
REQ-017 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-018 SHALL have port done, output, 1, one-cycle job-complete pulse.

Function
REQ-019 SHALL implement the FSM states IDLE, LOAD_W, STREAM, DRAIN and DONE.
REQ-020 SHALL go IDLE->LOAD_W on start with num_vec!=0, and IDLE->DONE on start with num_vec==0 (done pulse, no reads).
REQ-021 SHALL in LOAD_W assert w_rd_en for exactly ARRAY_SIZE cycles with w_addr 0..ARRAY_SIZE-1, then go to STREAM.
REQ-022 SHALL in STREAM assert d_rd_en for exactly num_vec cycles with d_addr 0..num_vec-1, then go to DRAIN.
REQ-023 SHALL in DRAIN remain exactly PIPE_LAT cycles, then go to DONE; DONE lasts 1 cycle, then goes to IDLE.
REQ-024 SHALL assert systolic_en in every STREAM and DRAIN cycle and in no other cycle.
REQ-025 SHALL generate out_valid as d_rd_en delayed by PIPE_LAT cycles (shift register); out_addr starts at 0 per job and increments after each out_valid cycle.
REQ-026 SHALL place the last out_valid in the final DRAIN cycle; done follows 1 cycle later.
REQ-027 SHALL give job latency from start cycle T: done at T+1+ARRAY_SIZE+num_vec+PIPE_LAT.
REQ-028 SHALL ignore start while busy; num_vec changes mid-job have no effect.
REQ-029 SHALL on abort in any non-IDLE state go to IDLE next cycle, clear counters and the out_valid pipe, and assert no done; abort in IDLE has no effect; abort has priority over every other transition.
REQ-030 SHALL honour start in the cycle immediately after DONE (back-to-back jobs).
REQ-031 SHALL keep address counters free of wrap within a job; num_vec max 2^ADDR_WIDTH-1.

Reset
REQ-032 SHALL on rst force asynchronously: state IDLE, all counters 0, the out_valid pipe 0, and all outputs 0 (busy, done, strobes, systolic_en, addresses).
REQ-033 SHALL on rst mid-job abandon the job with no done; the first start after rst release is honoured.

Verification
REQ-034 SHALL cover: ARRAY_SIZE=8, num_vec=4, start at cycle 0 -> w_rd_en cycles 1-8, weight_load cycles 2-9, d_rd_en cycles 9-12, systolic_en cycles 9-28, out_valid cycles 25-28 with out_addr 0-3, done at cycle 29, busy cycles 1-29.
REQ-035 SHALL cover: num_vec=0 with start -> done at cycle 1, no strobes, no systolic_en.
REQ-036 SHALL cover: abort at cycle 11 of the REQ-034 job -> all outputs 0 from cycle 12, no out_valid, no done.
REQ-037 SHALL cover: start held high through the whole job -> a second job starts at cycle 30 and its done arrives at cycle 59.
REQ-038 SHALL cover: rst asserted at cycle 20 -> outputs 0 immediately (asynchronous); a new start after release runs the full REQ-034 timing.
